// File: rtl/round_sd_arb_if.sv
// Sample bus for round_sd_arb: per-channel inputs in, one merged rounded stream plus sticky overrun flags out.
interface round_sd_arb_if #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 12,
    parameter int NCH       = 4
) ();
    logic [NCH*WIDTH_IN-1:0] in;
    logic [NCH-1:0]          strobe_in;
    logic [WIDTH_OUT-1:0]    out;
    logic [$clog2(NCH)-1:0]  chan_out;
    logic                    strobe_out;
    logic [NCH-1:0]          overrun;

    modport master (
        output in,
        output strobe_in,
        input  out,
        input  chan_out,
        input  strobe_out,
        input  overrun
    );

    modport slave (
        input  in,
        input  strobe_in,
        output out,
        output chan_out,
        output strobe_out,
        output overrun
    );
endinterface

// File: rtl/round_sd_arb.sv
// Per-channel error-feedback rounding of WIDTH_IN samples to WIDTH_OUT, round-robin merged onto one output; ROUND_SD_ARB_SAT_EN enables positive saturation.
// Latency: 2 cycles strobe_in -> strobe_out for an uncontended channel, plus 1 per channel served ahead.
// No backpressure: a strobe on a channel still pending overwrites its sample and sets sticky overrun.
module round_sd_arb #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 12,
    parameter int NCH       = 4
) (
    input  logic          clk,
    input  logic          reset,
    round_sd_arb_if.slave bus
);
    localparam int D  = WIDTH_IN - WIDTH_OUT;
    localparam int CW = $clog2(NCH);
`ifdef ROUND_SD_ARB_SAT_EN
    localparam int SW = WIDTH_IN + 1;
`else
    // The carry bit above the sample only matters when saturating; wrapping needs the low bits only.
    localparam int SW = WIDTH_IN;
`endif

    logic [WIDTH_IN-1:0]  held [NCH];
    logic [D-1:0]         err  [NCH];
    logic [NCH-1:0]       pending;
    logic [CW-1:0]        last;

    logic                 grant_vld;
    logic [CW-1:0]        grant_idx;
    logic [SW-1:0]        sum;
    logic [WIDTH_OUT-1:0] rounded;

    // Scan downwards so the closest pending channel after the last grant wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NCH; i >= 1; i--) begin
            if (pending[last + CW'(i)]) begin
                grant_vld = 1'b1;
                grant_idx = last + CW'(i);
            end
        end
    end

    always_comb begin
        sum = SW'($signed(held[grant_idx])) + SW'(err[grant_idx]);
`ifdef ROUND_SD_ARB_SAT_EN
        if (sum[WIDTH_IN] != sum[WIDTH_IN-1]) begin
            rounded = {1'b0, {(WIDTH_OUT-1){1'b1}}};
        end else begin
            rounded = sum[WIDTH_IN-1:D];
        end
`else
        rounded = sum[WIDTH_IN-1:D];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                held[c] <= '0;
                err[c]  <= '0;
            end
            pending        <= '0;
            last           <= CW'(NCH - 1);
            bus.out        <= '0;
            bus.chan_out   <= '0;
            bus.strobe_out <= 1'b0;
            bus.overrun    <= '0;
        end else begin
            bus.strobe_out <= grant_vld;
            if (grant_vld) begin
                bus.out        <= rounded;
                bus.chan_out   <= grant_idx;
                err[grant_idx] <= sum[D-1:0];
                last           <= grant_idx;
            end
            for (int c = 0; c < NCH; c++) begin
                if (bus.strobe_in[c]) begin
                    held[c]    <= bus.in[c*WIDTH_IN +: WIDTH_IN];
                    pending[c] <= 1'b1;
                    if (pending[c] && !(grant_vld && grant_idx == CW'(c))) begin
                        bus.overrun[c] <= 1'b1;
                    end
                end else if (grant_vld && grant_idx == CW'(c)) begin
                    pending[c] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/round_sd_arb.md
ROUND_SD_ARB -- requirements
Module: round_sd_arb

Interface
REQ-001 Parameter WIDTH_IN, default 16, SHALL set the input sample width in two's complement.
REQ-002 Parameter WIDTH_OUT, default 12, SHALL set the output sample width; WIDTH_OUT < WIDTH_IN.
REQ-003 Parameter NCH, default 4, SHALL set the channel count; legal values are 2, 4 and 8.
REQ-004 Port clk, input, 1, SHALL be the single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-006 Port in, input, NCH*WIDTH_IN, SHALL carry the per-channel samples; channel c occupies bits [c*WIDTH_IN +: WIDTH_IN].
REQ-007 Port strobe_in, input, NCH, SHALL mark valid samples; bit c qualifies channel c.
REQ-008 Port out, output, WIDTH_OUT, SHALL carry the rounded sample.
REQ-009 Port chan_out, output, log2(NCH), SHALL carry the channel index of out.
REQ-010 Port strobe_out, output, 1, SHALL be a one-cycle valid for out and chan_out.
REQ-011 Port overrun, output, NCH, SHALL carry sticky per-channel overrun flags.

Function
REQ-012 Each channel SHALL have a one-entry holding register, a pending bit and an error register err[c] of WIDTH_IN-WIDTH_OUT bits (unsigned).
REQ-013 When strobe_in[c] is high, the block SHALL capture in[c] into the holding register and set pending[c] on the next edge.
REQ-014 The block SHALL grant at most one pending channel per cycle, using round-robin arbitration that starts at (last granted + 1) mod NCH.
REQ-015 A grant SHALL clear pending[c], unless strobe_in[c] is high in the same cycle; in that case the old value is consumed, the new value is captured and pending stays set.
REQ-016 If strobe_in[c] is high while pending[c] is set and channel c is not granted that cycle, the block SHALL overwrite the held value and set overrun[c].
REQ-017 Arithmetic: sum = sign-extend(held[c]) + zero-extend(err[c]), WIDTH_IN+1 bits; new err[c] = sum[WIDTH_IN-WIDTH_OUT-1:0], written on the grant cycle.
REQ-018 Output: out = sum[WIDTH_IN:WIDTH_IN-WIDTH_OUT] narrowed to WIDTH_OUT, per REQ-025/026; out, chan_out and strobe_out are registered one edge after the grant.
REQ-019 Latency SHALL be exactly 2 cycles from strobe_in to strobe_out for an uncontended channel, plus 1 cycle per channel served ahead of it.
REQ-020 When no grant occurs, strobe_out SHALL be 0 and out/chan_out SHALL hold their last values.
REQ-021 err of non-granted channels SHALL be unchanged.

Reset
REQ-022 Reset SHALL clear out, chan_out, strobe_out, overrun, all pending bits, all err registers and all holding registers to 0.
REQ-023 After reset the arbiter pointer SHALL give channel 0 first priority (last granted = NCH-1).
REQ-024 Reset mid-operation SHALL drop all pending samples; no strobe_out is issued for them.

Configuration
REQ-025 With ROUND_SD_ARB_SAT_EN defined, a result whose sum[WIDTH_IN] and sum[WIDTH_IN-1] differ SHALL saturate to 2^(WIDTH_OUT-1)-1.
REQ-026 Without ROUND_SD_ARB_SAT_EN, out SHALL be sum[WIDTH_IN-1:WIDTH_IN-WIDTH_OUT] (wraps); err behaviour is identical in both modes.

Verification (WIDTH_IN=8, WIDTH_OUT=5, NCH=4)
REQ-027 Dither: ch0 in=5, strobed every 2nd cycle x8 -> out 0,1,0,1,1,0,1,1 (sum 5), err sequence 5,2,7,4,1,6,3,0.
REQ-028 Fan-in: all strobe_in high in one cycle, in=8,16,24,32 -> out 1,2,3,4 with chan_out 0,1,2,3 on consecutive cycles at latency 2,3,4,5; overrun=0.
REQ-029 Overrun: REQ-028 stimulus, then ch3 strobed again next cycle with 40 -> overrun[3]=1 sticky, ch3 out=5, only 4 strobe_out total.
REQ-030 Saturation: ch0 in=127 twice -> out 15, then 15 with SAT_EN (-16 / 5'b10000 without); err 7 then 6.
REQ-031 Negative: ch1 in=-8 with err 0 -> out 5'b11111 (-1), err[1]=0.
REQ-032 Reset: assert reset one cycle with pending and err nonzero -> no strobe_out afterwards; then ch0 in=5 gives first out 0.
